// File: rtl/alu_pkg.sv
// alu_pkg: ALU widths, opcode encodings and requester ids shared by the ALU sharing block.
package alu_pkg;
    localparam int ALU_W   = 16;
    localparam int ALU_OPW = 4;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_SHL    = 4'b0101;
    localparam logic [3:0] OP_SHR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_AUX = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; rr_ptr names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic rr_ptr;
    always_comb begin
        gnt = 2'b00;
        if (en && !rst) gnt = (req == 2'b11) ? (rr_ptr ? 2'b10 : 2'b01) : req;
    end
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= 1'b0;
        else if (|gnt) rr_ptr <= ~gnt[1];
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two requesters,
// with an exec register feeding the ALU and a result register behind a valid/ready handshake.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [OPW-1:0]   op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);
    logic             e_valid, e_id;
    logic [OPW-1:0]   e_op;
    logic [WIDTH-1:0] e_a, e_b;
    logic             adv_r, adv_e;
    logic [1:0]       gnt;

    assign adv_r = !rsp_valid || rsp_ready;
    assign adv_e = !e_valid || adv_r;

    rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .req({req1, req0}),
        .en (adv_e),
        .gnt(gnt)
    );

    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    // The ALU sees the exec register directly, so its output is stable for the whole exec cycle.
    assign alu_op = e_op;
    assign alu_a  = e_a;
    assign alu_b  = e_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid   <= 1'b0;
            e_id      <= REQ_EXE;
            e_op      <= '0;
            e_a       <= '0;
            e_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_EXE;
            rsp_data  <= '0;
        end else begin
            if (|gnt) begin
                e_valid <= 1'b1;
                e_id    <= gnt[1] ? REQ_AUX : REQ_EXE;
                e_op    <= gnt[1] ? op1 : op0;
                e_a     <= gnt[1] ? a1 : a0;
                e_b     <= gnt[1] ? b1 : b0;
            end else if (adv_e) begin
                e_valid <= 1'b0;
            end
            if (adv_r) begin
                rsp_valid <= e_valid;
                rsp_id    <= e_id;
                rsp_data  <= alu_out;
            end
        end
    end
endmodule
